// File: rtl/hex_7seg_scan_driver.sv
// -----------------------------------------------------------------------------
// hex_7seg_scan_driver
//
// Time-multiplexed driver for an N-digit seven-segment display with shared
// segment lines. A hexadecimal value is captured on i_load into a display
// register. The driver then scans one digit per refresh period. For each digit
// it drives a one-hot active-high digit enable and that digit's decoded
// segments. All outputs are registered. o_an and o_seg always update on the
// same edge, so a digit is never enabled with another digit's segments.
//
// Parameters:
//   N_DIGITS     number of digits scanned (1..8)
//   REFRESH_DIV  clock cycles each digit stays enabled (>= 2)
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_value   4*N_DIGITS hex value; nibble k drives digit k
//   i_load    capture i_value into the display register at this edge
//   o_seg     segments {a,b,c,d,e,f,g}, bit 6 = a, 1 = lit
//   o_an      one-hot digit enable, bit k = digit k
//   o_frame   one-cycle pulse when the scan wraps back to digit 0
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digit k (k >= 1) is blanked while
//                          nibbles k..N_DIGITS-1 are all zero. Digit 0 is
//                          never blanked.
// -----------------------------------------------------------------------------
module hex_7seg_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*N_DIGITS-1:0]   i_value,
  input  logic                    i_load,
  output logic [6:0]              o_seg,
  output logic [N_DIGITS-1:0]     o_an,
  output logic                    o_frame
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] r_disp;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_run;
  logic [6:0]            r_seg;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame;

  logic [3:0]            w_nib;
  logic [N_DIGITS-1:0]   w_an;
  logic                  w_blank;
  logic                  w_upper_zero;
  logic [6:0]            w_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

  // Select the nibble and enable of the digit currently indexed.
  always_comb begin
    w_nib = 4'h0;
    w_an  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib   = r_disp[4*k +: 4];
        w_an[k] = 1'b1;
      end
    end
  end

  // Blank decision. Walking from the top digit down, w_upper_zero stays set
  // while every nibble so far is zero. The indexed digit is blanked if the
  // flag is still set when the walk reaches it. Digit 0 is never visited.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    w_blank      = 1'b0;
    w_upper_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero && (r_disp[4*k +: 4] == 4'h0);
      if ((r_idx == IDX_W'(k)) && w_upper_zero)
        w_blank = 1'b1;
    end
  end
`else
  always_comb begin
    w_blank      = 1'b0;
    w_upper_zero = 1'b0;
  end
`endif

  assign w_seg = w_blank ? 7'b0000000 : f_decode(w_nib);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_disp  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_run   <= 1'b0;
      r_seg   <= 7'b0000000;
      r_an    <= '0;
      r_frame <= 1'b0;
    end else begin
      r_run <= 1'b1;

      // Capture and scan advance are independent at the same edge, so a load
      // never costs a scan step.
      if (i_load)
        r_disp <= i_value;

      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Outputs follow the pre-edge index and display register. An index of
      // 0 with a count of 0 means the scan has just wrapped. r_run suppresses
      // the first edge after reset, where o_an comes up from all-zero rather
      // than from the last digit.
      r_an    <= w_an;
      r_seg   <= w_seg;
      r_frame <= r_run && (r_cnt == '0) && (r_idx == '0);
    end
  end

  assign o_seg   = r_seg;
  assign o_an    = r_an;
  assign o_frame = r_frame;

endmodule

// File: doc/hex_7seg_scan_driver.md
# hex_7seg_scan_driver

Parametrised, time-multiplexed driver for a multi-digit common-anode/cathode seven-segment display. It latches an N-digit hexadecimal value on a load strobe, then scans one digit per refresh period, driving one-hot digit enables and that digit's decoded segments. It sits between the binary adder datapath and the board display pins. It supersedes single-digit combinational decoding for boards with shared segment lines.

## Interface
Parameters:
- N_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 1000: clock cycles each digit stays enabled; legal ≥ 2. Counter width is $clog2(REFRESH_DIV).

Ports:
- i_clk  input  1  system clock; all state on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_value  input  4*N_DIGITS  hex value; nibble k (bits 4k+3:4k) drives digit k, digit 0 least significant.
- i_load  input  1  when high at a clock edge, i_value is captured into the display register.
- o_seg  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a; 1 = lit.
- o_an  output  N_DIGITS  one-hot digit enable, active-high; bit k enables digit k.
- o_frame  output  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- State: display register (4*N_DIGITS), refresh counter, digit index (0..N_DIGITS-1), registered o_seg/o_an/o_frame.
- Refresh counter counts 0..REFRESH_DIV-1, then returns to 0. At terminal count the digit index increments; N_DIGITS-1 wraps to 0.
- o_an = one-hot(index). o_seg = decode(display nibble[index]), both registered.
- Decode table, values 0..F in order: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
- o_frame is high for exactly the one cycle in which o_an changes to digit 0 from digit N_DIGITS-1.
- If N_DIGITS = 1, o_an stays 1 after reset. o_frame pulses every REFRESH_DIV cycles.
- i_load may be asserted at any cycle, including on an index advance. The capture and the advance both take effect at the same edge, with no lost scan step.
- Held i_load recaptures on every edge.

## Timing
- Reset (async assert, sync to edge on release): counter 0, index 0, display register 0. o_seg = 0000000, o_an = all 0, o_frame = 0.
- First edge after reset release: o_an = one-hot digit 0, o_seg = decode(nibble 0) = 1111110.
- From then on, each digit is enabled for exactly REFRESH_DIV cycles. A full frame is N_DIGITS*REFRESH_DIV cycles.
- Load latency: at edge E, i_load is sampled high and the display register updates. o_seg shows the new data at edge E+1, if the digit is currently scanned.
- Index-to-output latency: 1 cycle. o_an and o_seg always change on the same edge, so there is no mismatched digit/segment cycle.
- Reset asserted mid-scan: all outputs go to reset values immediately, without waiting for a clock edge. The scan restarts from digit 0.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit k (k ≥ 1) is blanked if nibbles k..N_DIGITS-1 of the display register are all zero.
  - A blanked digit drives o_seg = 0000000, while o_an still asserts its bit.
  - Digit 0 is never blanked.
- Not defined: every digit is decoded normally, and zero shows as 1111110.

## Test plan
- Reset values: hold i_rst_n low for 5 cycles → o_seg = 0000000, o_an = 0000, o_frame = 0. Release → next edge gives o_an = 0001, o_seg = 1111110.
- Scan order (N_DIGITS=4, REFRESH_DIV=4): free-run 40 cycles → o_an follows 0001, 0010, 0100, 1000, each for exactly 4 cycles, then repeats. o_frame pulses once per 16 cycles, in the cycle o_an returns to 0001.
- Decode sweep (N_DIGITS=1): load values 0..F one per frame → o_seg matches the 16-entry table above, each valid one cycle after its load.
- Load mid-digit: while digit 1 is shown with value 0x1234, pulse i_load with 0xABCD → o_seg changes from 1111001 to 1001110 one edge later. o_an is unchanged until the period ends.
- Leading-zero blanking: load 0x0042 with LEADING_ZERO_BLANK_EN → digits 3 and 2 give o_seg 0000000, digit 1 gives 0110011, digit 0 gives 1101101. Without the macro, digits 3 and 2 give 1111110. Load 0x0000 → only digit 0 is lit, with 1111110.
- Async reset mid-scan: assert i_rst_n low between edges while digit 2 is active → outputs reach reset values before the next edge. After release, the scan resumes at digit 0 with a full REFRESH_DIV period.
